// File: rtl/idct_1d_seq.sv
// 8-point 1D inverse DCT built around a single time-shared multiply-accumulate.
// Coefficients X[0..7] are written into a local bank while idle. A start request
// then walks the cosine table for 64 cycles, one product per cycle. Each finished
// sample x[n] is rounded, saturated and latched onto its own parallel output.
module idct_1d_seq #(
    parameter int COEF_W = 16,
    parameter int OUT_W  = 8,
    parameter int ACC_W  = 36
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     load,
    input  logic [2:0]               load_idx,
    input  logic signed [COEF_W-1:0] load_data,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic signed [OUT_W-1:0]  x0,
    output logic signed [OUT_W-1:0]  x1,
    output logic signed [OUT_W-1:0]  x2,
    output logic signed [OUT_W-1:0]  x3,
    output logic signed [OUT_W-1:0]  x4,
    output logic signed [OUT_W-1:0]  x5,
    output logic signed [OUT_W-1:0]  x6,
    output logic signed [OUT_W-1:0]  x7
);

    localparam int PROD_W = COEF_W + 16;
    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(8192);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = -SAT_MAX - ACC_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic signed [COEF_W-1:0] coef [8];
    logic signed [OUT_W-1:0]  xr [8];
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_nxt;
    logic signed [15:0]       rom_nk;
    logic signed [PROD_W-1:0] prod;
    logic [2:0]               n;
    logic [2:0]               k;

    // 8192 * cos(m*pi/16) for the first quadrant, m = 0..8 (Q2.14 with c(k)/2 = 1/2 folded in)
    function automatic logic signed [15:0] cos_tab(input logic [4:0] m);
        case (m)
            5'd0:    return 16'sd8192;
            5'd1:    return 16'sd8035;
            5'd2:    return 16'sd7568;
            5'd3:    return 16'sd6811;
            5'd4:    return 16'sd5793;
            5'd5:    return 16'sd4551;
            5'd6:    return 16'sd3135;
            5'd7:    return 16'sd1598;
            default: return 16'sd0;
        endcase
    endfunction

    // rom[n][k]: fold the angle (2n+1)k*pi/16 into the first quadrant and look it up.
    // The product is taken modulo 32 because cos has period 32 in units of pi/16.
    function automatic logic signed [15:0] rom_val(input logic [2:0] nn, input logic [2:0] kk);
        logic [4:0] m;
        logic [4:0] r;
        logic [4:0] ri;
        m = {1'b0, nn, 1'b1} * {2'b00, kk};
        r = (m > 5'd16) ? (5'd0 - m) : m;
        ri = (r > 5'd8) ? (5'd16 - r) : r;
        if (kk == 3'd0)
            return 16'sd5793;
        else if (r > 5'd8)
            return -cos_tab(ri);
        else
            return cos_tab(ri);
    endfunction

    // Round half up on the 14 fractional bits, arithmetic shift keeps the sign
    function automatic logic signed [ACC_W-1:0] rnd(input logic signed [ACC_W-1:0] a);
        return (a + RND_HALF) >>> 14;
    endfunction

    // Clamp to the signed output range
    function automatic logic signed [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] a);
        if (a > SAT_MAX)
            return SAT_MAX[OUT_W-1:0];
        else if (a < SAT_MIN)
            return SAT_MIN[OUT_W-1:0];
        else
            return a[OUT_W-1:0];
    endfunction

    // MAC datapath: one full-precision product per cycle added to the running sum
    always_comb begin
        rom_nk  = rom_val(n, k);
        prod    = PROD_W'(coef[k]) * PROD_W'(rom_nk);
        acc_nxt = acc + ACC_W'(prod);
    end

    // Next-state logic and Moore outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = MAC;
            end
            MAC: begin
                busy = 1'b1;
                if (n == 3'd7 && k == 3'd7)
                    state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, coefficient bank, accumulator, indices and sample registers
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            acc   <= '0;
            n     <= '0;
            k     <= '0;
            for (int i = 0; i < 8; i++) begin
                coef[i] <= '0;
                xr[i]   <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (load)
                        coef[load_idx] <= load_data;
                    if (start) begin
                        acc <= '0;
                        n   <= '0;
                        k   <= '0;
                    end
                end
                MAC: begin
                    if (k == 3'd7) begin
                        xr[n] <= sat(rnd(acc_nxt));
                        acc   <= '0;
                        k     <= '0;
                        n     <= n + 3'd1;
                    end else begin
                        acc <= acc_nxt;
                        k   <= k + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign x0 = xr[0];
    assign x1 = xr[1];
    assign x2 = xr[2];
    assign x3 = xr[3];
    assign x4 = xr[4];
    assign x5 = xr[5];
    assign x6 = xr[6];
    assign x7 = xr[7];

endmodule
